// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the combinational ROM and
// buffers {PC, instr} pairs in a small FIFO handed to decode over valid/ready.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  input  logic                  PCSrc_i,
  input  logic [DATA_WIDTH-1:0] PCTarget_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]         C_DEPTH = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         C_ONE   = CW'(1);
  localparam logic [PW-1:0]         C_PONE  = PW'(1);
  localparam logic [DATA_WIDTH-1:0] C_FOUR  = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  w_pop;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_target;

  assign w_pop    = valid_o & ready_i;
  assign w_push   = ~PCSrc_i & ((r_count < C_DEPTH) | w_pop);
  assign w_target = {PCTarget_i[DATA_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (PCSrc_i) begin
      // Flush: a same-cycle pop still counts as delivered to decode.
      r_pc    <= w_target;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + C_FOUR;
        r_wptr <= r_wptr + C_PONE;
      end
      if (w_pop) r_rptr <= r_rptr + C_PONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_fifo_instr[r_wptr] <= imem_instr_i;
      r_fifo_pc[r_wptr]    <= r_pc;
    end
  end

  assign imem_addr_o = r_pc;
  assign valid_o     = (r_count != '0);
  assign Instr_o     = valid_o ? r_fifo_instr[r_rptr] : '0;
  assign PC_o        = valid_o ? r_fifo_pc[r_rptr] : '0;
  assign PCPlus4_o   = PC_o + C_FOUR;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus side predicts the accepted PC
// stream, a negedge monitor compares every decode transfer against it.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        PCSrc_i;
  logic [31:0] PCTarget_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] Instr_o;
  logic [31:0] PC_o;
  logic [31:0] PCPlus4_o;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] m_pc;
  logic        redir_pend;
  logic [31:0] redir_tgt;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr_o  (imem_addr_o),
    .imem_instr_i (imem_instr_i),
    .PCSrc_i      (PCSrc_i),
    .PCTarget_i   (PCTarget_i),
    .ready_i      (ready_i),
    .valid_o      (valid_o),
    .Instr_o      (Instr_o),
    .PC_o         (PC_o),
    .PCPlus4_o    (PCPlus4_o)
  );

  always #5 clk = ~clk;

  // ROM: word k holds "addi x(k+1), x0, 5*(k+1)" (0x00500093, 0x00A00113, ...)
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] k;
    logic [31:0] imm;
    k   = {2'b00, a[31:2]} + 32'd1;
    imm = k * 32'd5;
    return {imm[11:0], 5'd0, 3'd0, k[4:0], 7'h13};
  endfunction

  assign imem_instr_i = rom(imem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model tops up the predicted accept stream.
  task automatic drive(input logic rdy, input logic src, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    ready_i    = rdy;
    PCSrc_i    = src;
    PCTarget_i = tgt;
    if (src) m_pc = {tgt[31:2], 2'b00};
    else begin
      while (exp_q.size() < 8) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Reset asserted between edges, held across one edge, released after the next.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    ready_i = 1'b0;
    PCSrc_i = 1'b0;
    #1;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_pc_o", PC_o, 32'h0);
    check("rst_instr_o", Instr_o, 32'h0);
    check("rst_pcplus4", PCPlus4_o, 32'h4);
    exp_q.delete();
    m_pc = 32'h0;
    @(posedge clk);
    #1;
    check("rst_hold_addr", imem_addr_o, 32'h0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      redir_pend = 1'b0;
    end else begin
      if (redir_pend) begin
        check("valid_after_redirect", {31'd0, valid_o}, 32'd0);
        check("addr_after_redirect", imem_addr_o, redir_tgt);
      end
      if (!valid_o) begin
        check("idle_pc_o", PC_o, 32'h0);
        check("idle_instr_o", Instr_o, 32'h0);
      end else if (!ready_i && exp_q.size() > 0) begin
        check("stall_head_pc", PC_o, exp_q[0]);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", PC_o, 32'hXXXX_XXXX);
        end else begin
          e = exp_q.pop_front();
          check("pc_o", PC_o, e);
          check("instr_o", Instr_o, rom(e));
          check("pcplus4_o", PCPlus4_o, e + 32'd4);
        end
      end
      redir_pend = PCSrc_i;
      if (PCSrc_i) begin
        redir_tgt = {PCTarget_i[31:2], 2'b00};
        exp_q.delete();
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    ready_i    = 1'b0;
    PCSrc_i    = 1'b0;
    PCTarget_i = 32'h0;
    m_pc       = 32'h0;
    redir_pend = 1'b0;
    redir_tgt  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_addr", imem_addr_o, 32'h0);
    check("reset_pcplus4", PCPlus4_o, 32'h4);
    rst_n = 1'b1;

    // Streaming from reset: valid one edge after release, 1 instr/cycle.
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("first_valid", {31'd0, valid_o}, 32'd1);
    check("first_pc", PC_o, 32'h0);
    check("first_instr", Instr_o, 32'h0050_0093);
    repeat (8) drive(1'b1, 1'b0, 32'h0);

    // Mid-stream async reset, then stall until full.
    async_reset();
    repeat (5) drive(1'b0, 1'b0, 32'h0);
    check("stall_addr", imem_addr_o, 32'h8);
    check("stall_head", PC_o, 32'h0);
    check("stall_valid", {31'd0, valid_o}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check("full_stream_valid", {31'd0, valid_o}, 32'd1);
    end

    // Redirect with two entries buffered and no pop.
    repeat (2) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0042);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("redirect_head", PC_o, 32'h40);
    repeat (3) drive(1'b1, 1'b0, 32'h0);

    // PC wrap through the top of the address space.
    drive(1'b1, 1'b1, 32'hFFFF_FFFE);
    repeat (5) drive(1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic        src;
      logic        rdy;
      logic [31:0] tgt;
      src = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = $urandom;
      if (i == 1500) async_reset();
      drive(rdy, src, tgt);
    end

    repeat (3) drive(1'b0, 1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of instr_mem and feeds the decode stage.
- Owns the program counter and drives the byte address into the combinational instruction ROM (little-endian, 32-bit word per address).
- Captures each returned word with its PC into a small FIFO.
- Hands entries to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- FIFO_DEPTH, 2, number of buffered fetch entries; power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr_o  output  DATA_WIDTH  byte address to instruction memory (equals PC register).
- imem_instr_i  input  DATA_WIDTH  instruction word returned combinationally for imem_addr_o.
- PCSrc_i  input  1  redirect request from execute (taken branch/jump).
- PCTarget_i  input  DATA_WIDTH  redirect target address.
- ready_i  input  1  decode can accept the head entry this cycle.
- valid_o  output  1  head entry valid.
- Instr_o  output  DATA_WIDTH  head entry instruction.
- PC_o  output  DATA_WIDTH  head entry PC.
- PCPlus4_o  output  DATA_WIDTH  PC_o + 4 (combinational, wraps modulo 2^DATA_WIDTH).

Behaviour:
- Reset (rst_n low, async, takes effect immediately):
  - PC ← RESET_PC; FIFO empty (count=0, read/write pointers 0).
  - valid_o=0, Instr_o=0, PC_o=0, PCPlus4_o=4.
  - Release is sampled on clk rising edge; no fetch occurs while rst_n is low.
- imem_addr_o = PC register at all times (combinational); imem_instr_i is treated as valid in the same cycle.
- pop = valid_o & ready_i.
- push = !PCSrc_i & ((count < FIFO_DEPTH) | pop): enqueue {PC, imem_instr_i}; PC ← PC + 4.
- Full with no pop: no push, PC holds, imem_addr_o stable.
- Simultaneous push and pop when full: allowed; count unchanged.
- Redirect (PCSrc_i=1) has priority over push:
  - PC ← {PCTarget_i[DATA_WIDTH-1:2], 2'b00} (low bits forced zero); no push that cycle.
  - All FIFO entries are discarded; count ← 0 at the edge.
  - A pop in the same cycle completes normally; that head transfer counts as accepted.
  - valid_o=0 on the cycle after redirect; the target's instruction is pushed that cycle and is valid_o one cycle later (redirect-to-valid latency = 2 edges).
- valid_o = (count != 0). Instr_o/PC_o show the head entry when valid, else 0.
- Latency: first valid_o rises one edge after reset release. Steady throughput is 1 instr/cycle with ready_i held high.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count is $clog2(FIFO_DEPTH+1) bits.
- PC wraps: 0xFFFF_FFFC + 4 → 0x0000_0000; no exception.
- Valid/ready rules:
  - While valid_o=1 and ready_i=0, Instr_o/PC_o hold stable until popped or flushed.
  - valid_o never depends combinationally on ready_i.
- No combinational path from PCSrc_i/PCTarget_i to imem_addr_o. Redirect takes effect at the next edge.

Test Plan:
- Reset then ready_i=1, ROM words 0x00500093, 0x00A00113, … at 0x0, 0x4, … → valid_o high from cycle 1; PC_o = 0x0, 0x4, 0x8 on consecutive cycles; Instr_o matches ROM; PCPlus4_o = PC_o+4.
- ready_i=0 for 5 cycles after reset → exactly FIFO_DEPTH (2) pushes; PC stalls at 0x8; head holds PC_o=0x0. Raise ready_i → PC_o 0x0, 0x4, 0x8 with no gap or duplicate.
- Full FIFO, ready_i=1 with pop+push each cycle → count stays 2 and the PC sequence is contiguous.
- PCSrc_i=1, PCTarget_i=0x0000_0042 while 2 entries are buffered → next cycle valid_o=0 and imem_addr_o=0x40; the following cycle PC_o=0x40 with old entries gone.
- Load PC 0xFFFF_FFFC via redirect → entries PC_o=0xFFFF_FFFC then 0x0000_0000.
- Assert rst_n low mid-stream asynchronously (between edges) → valid_o=0 and imem_addr_o=RESET_PC immediately. After release, the sequence restarts from RESET_PC.
